// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one data-memory transaction per request over req/gnt/rvalid, with
// byte-lane steering for stores, load extension for writeback and error reporting.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  load_variant,
  input  logic [2:0]  store_variant,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               wb_valid_q, wb_valid_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         lvar_q, lvar_d;
  logic [4:0]         rd_q, rd_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               to_hit;
  logic [1:0]         acc_size;
  logic               misaligned;

  // Access size: 0 byte, 1 half, 2 word; unknown variants fall back to word.
  function automatic logic [1:0] load_size(input logic [2:0] v);
    case (v)
      3'b000, 3'b100: load_size = 2'd0;
      3'b001, 3'b101: load_size = 2'd1;
      default:        load_size = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] store_size(input logic [2:0] v);
    case (v)
      3'b000:  store_size = 2'd0;
      3'b001:  store_size = 2'd1;
      default: store_size = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] v, input logic [1:0] off);
    case (v)
      3'b000:  store_be = 4'b0001 << off;
      3'b001:  store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] v, input logic [31:0] d);
    case (v)
      3'b000:  store_lanes = {4{d[7:0]}};
      3'b001:  store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] v, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (v)
      3'b000:  load_ext = 32'(b);
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = 32'(h);
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = rdata;
    endcase
  endfunction

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign to_hit     = (TIMEOUT != 0) && (cnt_inc >= TO_LIMIT);
  assign acc_size   = is_store ? store_size(store_variant) : load_size(load_variant);
  assign misaligned = ((acc_size == 2'd1) && addr[0]) ||
                      ((acc_size == 2'd2) && (addr[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    lvar_d      = lvar_q;
    rd_d        = rd_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && is_load && is_store) begin
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end else if (start && (is_load || is_store)) begin
          if (misaligned) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store;
            mem_addr_d = {addr[31:2], 2'b00};
            mem_be_d   = is_store ? store_be(store_variant, addr[1:0]) : 4'b1111;
            if (is_store) mem_wdata_d = store_lanes(store_variant, store_data);
            off_d      = addr[1:0];
            lvar_d     = load_variant;
            rd_d       = rd_in;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? S_IDLE : S_WAIT;
        end else if (to_hit) begin
          mem_req_d  = 1'b0;
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = load_ext(lvar_q, off_q, mem_rdata);
          wb_rd_d    = rd_q;
          state_d    = S_IDLE;
        end else if (to_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      cnt_q       <= '0;
      off_q       <= '0;
      lvar_q      <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      lvar_q      <= lvar_d;
      rd_q        <= rd_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: table of single transactions against a zero-wait memory,
// plus hand-written sequences for stalls, timeout and reset during a load.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, is_store;
  logic [2:0]  load_variant, store_variant;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .load_variant(load_variant), .store_variant(store_variant), .addr(addr),
    .store_data(store_data), .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .err(err), .err_code(err_code)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  lv;
    logic [2:0]  sv;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic        e;
    logic [1:0]  code;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] lv, input logic [2:0] sv,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
    start = 1'b1; is_load = ld; is_store = st; load_variant = lv; store_variant = sv;
    addr = a; store_data = sd; rd_in = rd;
    step();
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [4:0] rd;
    v  = vecs[i];
    rd = 5'(i + 3);
    issue(v.ld, v.st, v.lv, v.sv, v.a, v.sd, rd);
    if (v.e) begin
      chk($sformatf("v%0d err", i), 32'(err), 32'd1);
      chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(v.code));
      chk($sformatf("v%0d no req", i), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d idle", i), 32'(busy), 32'd0);
      step();
      chk($sformatf("v%0d err pulse", i), 32'(err), 32'd0);
      return;
    end
    chk($sformatf("v%0d req", i), 32'(mem_req), 32'd1);
    chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
    chk($sformatf("v%0d addr", i), mem_addr, v.maddr);
    chk($sformatf("v%0d we", i), 32'(mem_we), 32'(v.st));
    chk($sformatf("v%0d be", i), 32'(mem_be), 32'(v.be));
    if (v.st) chk($sformatf("v%0d wdata", i), mem_wdata, v.wdata);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk($sformatf("v%0d req drop", i), 32'(mem_req), 32'd0);
    if (v.st) begin
      chk($sformatf("v%0d store done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d store no wb", i), 32'(wb_valid), 32'd0);
      return;
    end
    chk($sformatf("v%0d wait busy", i), 32'(busy), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = v.rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'd1);
    chk($sformatf("v%0d wb_data", i), wb_data, v.wb);
    chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(rd));
    chk($sformatf("v%0d done", i), 32'(busy), 32'd0);
    step();
    chk($sformatf("v%0d wb pulse", i), 32'(wb_valid), 32'd0);
  endtask

  initial begin
    //           ld    st    lv      sv      addr          sdata         rdata         e     code   maddr         be       wdata         wb
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 1'b0, 2'b00, 32'h0000_1000, 4'b1111, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 1'b0, 3'b101, 3'b000, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 1'b0, 2'b00, 32'h0000_2000, 4'b1111, 32'h0,        32'h0000_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 1'b0, 2'b00, 32'h0000_2000, 4'b1111, 32'h0,        32'hFFFF_BEEF};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 3'b000, 32'h0000_1001, 32'h0,        32'h1234_A5FF, 1'b0, 2'b00, 32'h0000_1000, 4'b1111, 32'h0,        32'h0000_00A5};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0000_0040, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_0000, 32'h0,        32'h1234_7FFF, 1'b0, 2'b00, 32'h0000_0000, 4'b1111, 32'h0,        32'h0000_7FFF};
    vecs[6]  = '{1'b1, 1'b0, 3'b111, 3'b000, 32'h0000_0008, 32'h0,        32'h8765_4321, 1'b0, 2'b00, 32'h0000_0008, 4'b1111, 32'h0,        32'h8765_4321};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0011, 32'h1234_56AB, 32'h0,        1'b0, 2'b00, 32'h0000_0010, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 3'b001, 32'h0000_0022, 32'h0000_CAFE, 32'h0,        1'b0, 2'b00, 32'h0000_0020, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 3'b001, 32'h0000_0020, 32'h5555_1357, 32'h0,        1'b0, 2'b00, 32'h0000_0020, 4'b0011, 32'h1357_1357, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b000, 3'b010, 32'h0000_0030, 32'h1122_3344, 32'h0,        1'b0, 2'b00, 32'h0000_0030, 4'b1111, 32'h1122_3344, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0003, 32'h0000_00C3, 32'h0,        1'b0, 2'b00, 32'h0000_0000, 4'b1000, 32'hC3C3_C3C3, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b000, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        1'b1, 2'b01, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_0005, 32'h0,        32'h0,        1'b1, 2'b01, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[14] = '{1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0002, 32'h0,        32'h0,        1'b1, 2'b01, 32'h0,         4'b0000, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 1'b1, 3'b010, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 2'b11, 32'h0,         4'b0000, 32'h0,        32'h0};

    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    load_variant = 3'b000; store_variant = 3'b000; addr = 32'h0; store_data = 32'h0;
    rd_in = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_be", 32'(mem_be), 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst wb_data", wb_data, 32'h0);
    chk("rst wb_rd", 32'(wb_rd), 32'h0);
    chk("rst err_code", 32'(err_code), 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) run_vec(i);

    // start with neither flag set is ignored
    issue(1'b0, 1'b0, 3'b010, 3'b010, 32'h0000_0100, 32'h0, 5'd1);
    chk("nop req", 32'(mem_req), 32'd0);
    chk("nop busy", 32'(busy), 32'd0);
    chk("nop err", 32'(err), 32'd0);

    // SB with grant only in the third REQ cycle: request held stable
    issue(1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0011, 32'h1234_56AB, 5'd2);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sb stall req c%0d", c), 32'(mem_req), 32'd1);
      chk($sformatf("sb stall be c%0d", c), 32'(mem_be), 32'b0010);
      chk($sformatf("sb stall wdata c%0d", c), mem_wdata, 32'hABAB_ABAB);
      chk($sformatf("sb stall addr c%0d", c), mem_addr, 32'h0000_0010);
      if (c == 2) mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
    end
    chk("sb stall req drop", 32'(mem_req), 32'd0);
    chk("sb stall idle", 32'(busy), 32'd0);
    chk("sb stall no wb", 32'(wb_valid), 32'd0);

    // Load never granted: 16 REQ cycles then timeout; stray rvalid in REQ ignored
    issue(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0100, 32'h0, 5'd7);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("to req c%0d", c), 32'(mem_req), 32'd1);
      chk($sformatf("to no err c%0d", c), 32'(err), 32'd0);
      chk($sformatf("to no wb c%0d", c), 32'(wb_valid), 32'd0);
      mem_rvalid = (c == 3);
      step();
      mem_rvalid = 1'b0;
    end
    chk("to req drop", 32'(mem_req), 32'd0);
    chk("to err", 32'(err), 32'd1);
    chk("to err_code", 32'(err_code), 32'b10);
    chk("to busy", 32'(busy), 32'd0);
    chk("to no wb", 32'(wb_valid), 32'd0);
    step();
    chk("to err pulse", 32'(err), 32'd0);

    // Reset while waiting for load data; late rvalid must be dropped
    issue(1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0080, 32'h0, 5'd9);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rstmid in wait", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid idle", 32'(busy), 32'd0);
    chk("rstmid req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    chk("rstmid no wb", 32'(wb_valid), 32'd0);
    chk("rstmid no err", 32'(err), 32'd0);
    step();
    chk("rstmid no wb later", 32'(wb_valid), 32'd0);
    run_vec(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
